// File: rtl/fifo_buf_var_pkg.sv
// Shared helpers for the variable-rate parallel FIFO: modulo pointer advance
// and the width functions used to size counters and request ports.
package fifo_buf_var_pkg;

    // DEPTH need not be a power of two, so wrap by a single conditional subtract.
    function automatic int wrap_add(input int ptr, input int n, input int depth);
        return (ptr + n >= depth) ? (ptr + n - depth) : (ptr + n);
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int num_width(input int par);
        return $clog2(par + 1);
    endfunction

endpackage

// File: rtl/fifo_var_ptr.sv
// Circular pointer register advancing by a variable amount, modulo DEPTH.
module fifo_var_ptr
    import fifo_buf_var_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int NUM_W = 3,
    localparam int PTR_W = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             adv,
    input  logic [NUM_W-1:0] num,
    output logic [PTR_W-1:0] ptr
);

    logic [PTR_W-1:0] ptr_nxt;

    always_comb begin
        ptr_nxt = PTR_W'(wrap_add(int'(ptr), int'(num), DEPTH));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (adv) begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/fifo_buf_var.sv
// Parallel circular FIFO: up to PAR_WRITE words in and PAR_READ words out per
// cycle, show-ahead output lanes, synchronous flush and sticky error flags.
module fifo_buf_var
    import fifo_buf_var_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int PAR_WRITE  = 4,
    parameter int PAR_READ   = 2,
    localparam int CNT_W     = cnt_width(DEPTH),
    localparam int WN_W      = num_width(PAR_WRITE),
    localparam int RN_W      = num_width(PAR_READ)
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           flush,
    input  logic                           wen,
    input  logic [WN_W-1:0]                wr_num,
    input  logic [PAR_WRITE*DATA_WIDTH-1:0] din,
    input  logic                           ren,
    input  logic [RN_W-1:0]                rd_num,
    output logic [PAR_READ*DATA_WIDTH-1:0] dout,
    output logic [PAR_READ-1:0]            dout_vld,
    output logic                           wr_ready,
    output logic                           rd_valid,
    output logic [CNT_W-1:0]               count,
    output logic [CNT_W-1:0]               free,
    output logic                           ovf_err,
    output logic                           udf_err
);

    localparam int PTR_W = ptr_width(DEPTH);

    if (DEPTH < PAR_WRITE || DEPTH < PAR_READ) begin : g_bad_cfg
        $error("fifo_buf_var: DEPTH must be >= PAR_WRITE and >= PAR_READ");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_addr [PAR_WRITE];
    logic [PTR_W-1:0]      rd_addr [PAR_READ];
    logic [CNT_W-1:0]      count_nxt;

    logic wr_in_range;
    logic rd_in_range;
    logic wr_acc;
    logic rd_acc;
    logic ovf_set;
    logic udf_set;

    // Readiness looks only at start-of-cycle occupancy; out-of-range counts never qualify.
    assign wr_in_range = (wr_num != '0) && (int'(wr_num) <= PAR_WRITE);
    assign rd_in_range = (rd_num != '0) && (int'(rd_num) <= PAR_READ);
    assign wr_ready    = wr_in_range && (int'(free) >= int'(wr_num));
    assign rd_valid    = rd_in_range && (int'(count) >= int'(rd_num));

    assign wr_acc  = wen && wr_ready && !flush;
    assign rd_acc  = ren && rd_valid && !flush;
    assign ovf_set = wen && (wr_num != '0) && !wr_ready;
    assign udf_set = ren && (rd_num != '0) && !rd_valid;

    assign free = CNT_W'(DEPTH) - count;

    fifo_var_ptr #(
        .DEPTH (DEPTH),
        .NUM_W (WN_W)
    ) u_wr_ptr (
        .clk  (clk),
        .rstn (rstn),
        .clr  (flush),
        .adv  (wr_acc),
        .num  (wr_num),
        .ptr  (wr_ptr)
    );

    fifo_var_ptr #(
        .DEPTH (DEPTH),
        .NUM_W (RN_W)
    ) u_rd_ptr (
        .clk  (clk),
        .rstn (rstn),
        .clr  (flush),
        .adv  (rd_acc),
        .num  (rd_num),
        .ptr  (rd_ptr)
    );

    always_comb begin
        for (int unsigned i = 0; i < PAR_WRITE; i++) begin
            wr_addr[i] = PTR_W'(wrap_add(int'(wr_ptr), int'(i), DEPTH));
        end
        for (int unsigned j = 0; j < PAR_READ; j++) begin
            rd_addr[j] = PTR_W'(wrap_add(int'(rd_ptr), int'(j), DEPTH));
        end
    end

    always_comb begin
        count_nxt = count;
        if (wr_acc) begin
            count_nxt = count_nxt + CNT_W'(wr_num);
        end
        if (rd_acc) begin
            count_nxt = count_nxt - CNT_W'(rd_num);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count   <= '0;
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
        end else if (flush) begin
            count   <= '0;
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
        end else begin
            count <= count_nxt;
            if (ovf_set) begin
                ovf_err <= 1'b1;
            end
            if (udf_set) begin
                udf_err <= 1'b1;
            end
        end
    end

    // Flush leaves storage intact; the cleared count masks it via dout_vld.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned a = 0; a < DEPTH; a++) begin
                mem[a] <= '0;
            end
        end else if (wr_acc) begin
            for (int unsigned i = 0; i < PAR_WRITE; i++) begin
                if (i < 32'(wr_num)) begin
                    mem[wr_addr[i]] <= din[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_comb begin
        dout     = '0;
        dout_vld = '0;
        for (int unsigned j = 0; j < PAR_READ; j++) begin
            dout[j*DATA_WIDTH +: DATA_WIDTH] = mem[rd_addr[j]];
            dout_vld[j]                      = 32'(count) > j;
        end
    end

endmodule

// File: tb/tb_fifo_buf_var.sv
// Scoreboard bench for fifo_buf_var: a word queue models FIFO contents,
// acceptance rules and sticky flags; every DUT output is compared against it.
module tb_fifo_buf_var;

    logic        clk;
    logic        rstn;
    logic        flush;
    logic        wen;
    logic [2:0]  wr_num;
    logic [63:0] din;
    logic        ren;
    logic [1:0]  rd_num;
    logic [31:0] dout;
    logic [1:0]  dout_vld;
    logic        wr_ready;
    logic        rd_valid;
    logic [3:0]  count;
    logic [3:0]  free;
    logic        ovf_err;
    logic        udf_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] mq[$];
    logic        m_ovf = 1'b0;
    logic        m_udf = 1'b0;

    fifo_buf_var #(
        .DATA_WIDTH (16),
        .DEPTH      (8),
        .PAR_WRITE  (4),
        .PAR_READ   (2)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .flush    (flush),
        .wen      (wen),
        .wr_num   (wr_num),
        .din      (din),
        .ren      (ren),
        .rd_num   (rd_num),
        .dout     (dout),
        .dout_vld (dout_vld),
        .wr_ready (wr_ready),
        .rd_valid (rd_valid),
        .count    (count),
        .free     (free),
        .ovf_err  (ovf_err),
        .udf_err  (udf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        int          sz;
        logic [1:0]  vld;
        sz  = mq.size();
        vld = (sz >= 2) ? 2'b11 : (sz == 1) ? 2'b01 : 2'b00;
        check_eq("count", count, sz);
        check_eq("free", free, 8 - sz);
        check_eq("dout_vld", dout_vld, vld);
        check_eq("ovf_err", ovf_err, m_ovf);
        check_eq("udf_err", udf_err, m_udf);
        for (int j = 0; j < 2 && j < sz; j++) begin
            check_eq("dout_lane", dout[j*16 +: 16], mq[j]);
        end
    endtask

    // Inputs change at posedge+1; the model advances across the edge and
    // popped words are compared with the lanes seen just before the edge.
    task automatic cyc(input logic w, input int wn, input logic [63:0] d,
                       input logic r, input int rn, input logic f);
        logic        wok;
        logic        rok;
        int          cnt;
        logic [31:0] pre;
        logic [15:0] exp_word;
        wen    = w;
        wr_num = 3'(wn);
        din    = d;
        ren    = r;
        rd_num = 2'(rn);
        flush  = f;
        #1;
        cnt = mq.size();
        wok = (wn > 0) && (wn <= 4) && ((8 - cnt) >= wn);
        rok = (rn > 0) && (rn <= 2) && (cnt >= rn);
        check_eq("wr_ready", wr_ready, wok);
        check_eq("rd_valid", rd_valid, rok);
        pre = dout;
        @(posedge clk);
        if (f) begin
            mq.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            if (r && rok) begin
                for (int k = 0; k < rn; k++) begin
                    exp_word = mq.pop_front();
                    check_eq("rd_data", pre[k*16 +: 16], exp_word);
                end
            end
            if (w && wok) begin
                for (int k = 0; k < wn; k++) begin
                    mq.push_back(d[k*16 +: 16]);
                end
            end
            if (w && wn != 0 && !wok) m_ovf = 1'b1;
            if (r && rn != 0 && !rok) m_udf = 1'b1;
        end
        #1;
        check_state();
    endtask

    initial begin
        rstn   = 1'b0;
        flush  = 1'b0;
        wen    = 1'b0;
        wr_num = '0;
        din    = '0;
        ren    = 1'b0;
        rd_num = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_dout", dout, 0);
        check_state();
        rstn = 1'b1;

        // Idle after reset: wr_ready with wr_num 4, rd_valid low with rd_num 1
        cyc(0, 4, 64'h0, 0, 1, 0);
        cyc(0, 4, 64'h0, 0, 1, 0);
        check_eq("idle_dout", dout, 0);

        // Basic write then variable reads
        cyc(1, 4, 64'h0004_0003_0002_0001, 0, 0, 0);
        check_eq("first_dout", dout, 32'h0002_0001);
        cyc(0, 0, 64'h0, 1, 2, 0);
        check_eq("after_rd2", dout, 32'h0004_0003);
        cyc(0, 0, 64'h0, 1, 1, 0);
        check_eq("after_rd1_lane0", dout[15:0], 16'h0004);
        cyc(0, 0, 64'h0, 1, 1, 0);

        // Wrap-around with pointers offset
        cyc(1, 4, 64'h0004_0003_0002_0001, 0, 0, 0);
        cyc(1, 4, 64'h0008_0007_0006_0005, 0, 0, 0);
        check_eq("full_count", count, 8);
        cyc(0, 0, 64'h0, 1, 2, 0);
        cyc(0, 0, 64'h0, 1, 2, 0);
        cyc(0, 0, 64'h0, 1, 2, 0);
        cyc(1, 3, 64'hFFFF_000B_000A_0009, 0, 0, 0);
        check_eq("wrap_count", count, 5);
        cyc(0, 0, 64'h0, 1, 2, 0);
        cyc(0, 0, 64'h0, 1, 2, 0);
        cyc(0, 0, 64'h0, 1, 2, 0);
        cyc(0, 0, 64'h0, 1, 1, 0);

        // Full: rejected write, then simultaneous read/write at full
        cyc(1, 4, 64'h0014_0013_0012_0011, 0, 0, 0);
        cyc(1, 4, 64'h0018_0017_0016_0015, 0, 0, 0);
        cyc(1, 1, 64'h0000_0000_0000_0099, 0, 0, 0);
        check_eq("ovf_full", ovf_err, 1);
        cyc(1, 2, 64'h0000_0000_0088_0077, 1, 2, 0);
        check_eq("full_rw_count", count, 6);

        // Flush clears flags and occupancy; then out-of-range requests
        cyc(0, 0, 64'h0, 0, 0, 1);
        cyc(1, 5, 64'h1, 0, 0, 0);
        cyc(0, 0, 64'h0, 0, 0, 1);
        cyc(1, 4, 64'h0024_0023_0022_0021, 1, 3, 0);
        cyc(0, 0, 64'h0, 0, 0, 1);
        cyc(1, 0, 64'h1, 1, 0, 0);

        // Empty: write accepted, read rejected
        cyc(1, 1, 64'h0000_0000_0000_0005, 1, 1, 0);
        check_eq("empty_rw_lane0", dout[15:0], 16'h0005);

        // Flush at count 5 with a same-cycle write
        cyc(1, 4, 64'h0034_0033_0032_0031, 1, 3, 0);
        check_eq("pre_flush_count", count, 5);
        cyc(1, 4, 64'h0044_0043_0042_0041, 0, 0, 1);

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            cyc($urandom_range(0, 3) != 0, int'($urandom_range(0, 5)),
                {$urandom, $urandom},
                $urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
                $urandom_range(0, 40) == 0);
        end

        // Asynchronous reset mid-cycle
        cyc(0, 0, 64'h0, 0, 0, 1);
        cyc(1, 4, 64'h0054_0053_0052_0051, 0, 0, 0);
        cyc(1, 7, 64'h0, 1, 3, 0);
        #2;
        rstn = 1'b0;
        #1;
        mq.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        check_eq("async_dout", dout, 0);
        check_state();
        @(negedge clk);
        rstn = 1'b1;
        cyc(0, 0, 64'h0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_buf_var.md
Name: fifo_buf_var

Overview:
- Next-generation parallel circular FIFO for the accelerator datapath.
- Accepts 1..PAR_WRITE words and delivers 1..PAR_READ words per cycle, with a per-cycle variable count on both sides.
- Exposes occupancy, per-lane valid mask, synchronous flush and sticky overflow/underflow flags.
- Sits between wide producers (e.g. memory burst fetch) and narrower PE-array consumers.

Parameters:
DATA_WIDTH, 16, bits per word
DEPTH, 8, storage in words; any integer >= max(PAR_WRITE, PAR_READ), not required to be a power of two
PAR_WRITE, 4, max words written per cycle
PAR_READ, 2, max words read per cycle
CNT_W, $clog2(DEPTH+1), localparam, occupancy/free width
WN_W, $clog2(PAR_WRITE+1), localparam, wr_num width
RN_W, $clog2(PAR_READ+1), localparam, rd_num width

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
flush  in  1  synchronous clear
wen  in  1  write request
wr_num  in  WN_W  words to write this cycle; valid 1..PAR_WRITE
din  in  PAR_WRITE*DATA_WIDTH  word 0 in LSBs, written first
ren  in  1  read request
rd_num  in  RN_W  words to consume this cycle; valid 1..PAR_READ
dout  out  PAR_READ*DATA_WIDTH  show-ahead; lane j = j-th oldest word
dout_vld  out  PAR_READ  lane j valid iff j < count
wr_ready  out  1  free >= wr_num and wr_num != 0; combinational
rd_valid  out  1  count >= rd_num and rd_num != 0; combinational
count  out  CNT_W  stored words
free  out  CNT_W  DEPTH - count
ovf_err  out  1  sticky: write request rejected
udf_err  out  1  sticky: read request rejected

Behaviour:
- Reset (rstn low, asynchronous): wr_ptr = rd_ptr = 0; count = 0; free = DEPTH; flags = 0; memory = 0. Therefore dout = 0, dout_vld = 0, rd_valid = 0.
- Write accepted on a clk edge when wen && wr_ready.
  - Lane i (i < wr_num) is stored at (wr_ptr+i) mod DEPTH.
  - wr_ptr advances by wr_num, modulo DEPTH.
  - Lanes >= wr_num are ignored.
- Read accepted when ren && rd_valid. rd_ptr advances by rd_num, modulo DEPTH.
- Modulo rule: p + n >= DEPTH ? p + n - DEPTH : p + n. No power-of-two masking.
- count_next = count + (write accepted ? wr_num : 0) - (read accepted ? rd_num : 0).
- Latency:
  - Written data is visible on dout/dout_vld the cycle after the write edge.
  - dout updates the cycle after an accepted read.
- Readiness is evaluated from start-of-cycle count only; no same-cycle pass-through:
  - At full, simultaneous write+read: read accepted, write rejected.
  - At empty, simultaneous write+read: write accepted, read rejected.
- Rejections:
  - wen with wr_num = 0: no-op, no flag.
  - wen && wr_num > 0 && !wr_ready: ovf_err <= 1, state unchanged.
  - ren && rd_num = 0: no-op, no flag.
  - ren && rd_num > 0 && !rd_valid: udf_err <= 1.
- Out-of-range counts (wr_num > PAR_WRITE, rd_num > PAR_READ) are treated as rejected requests and set the matching flag.
- flush has priority over wen/ren in the same cycle:
  - Pointers, count and flags are cleared.
  - Memory contents are kept but invalid, since dout_vld = 0.
  - Same-cycle write is dropped.
- rstn asserted mid-operation: immediate clear regardless of clk.
- dout lanes with dout_vld = 0 show stale memory; benches check only valid lanes.
- Elaboration error if DEPTH < PAR_WRITE or DEPTH < PAR_READ.

Decomposition:
- Package fifo_buf_var_pkg:
  - function wrap_add(ptr, n, depth)
  - function clog2-based width helpers
- One sub-module fifo_var_ptr: pointer register with modulo advance, instantiated for write and read.
- Memory array and counters stay in the top module.

Test Plan:
- Reset, then hold 2 cycles -> count 0, free 8, dout 0, dout_vld 2'b00, wr_ready 1 with wr_num 4, rd_valid 0 with rd_num 1, flags 0.
- Write din {4,3,2,1}, wr_num 4 -> next cycle count 4, dout {2,1}, dout_vld 2'b11. Then read rd_num 2 -> dout {4,3}, count 2. Then read rd_num 1 -> dout lane0 = 4, dout_vld 2'b01.
- Wrap:
  - Write {4,3,2,1} then {8,7,6,5} -> count 8.
  - Read 2 three times -> count 2.
  - Write {x,11,10,9} with wr_num 3 -> count 5.
  - Successive rd_num 2 reads yield 7,8,9,10,11 in order.
- Full, count 8:
  - wen wr_num 1 -> rejected, ovf_err 1, count 8.
  - Same cycle ren rd_num 2 + wen wr_num 2 -> read accepted, write rejected, count 6.
- Empty: wen wr_num 1 with din lane0 = 5, plus ren rd_num 1 -> write accepted, udf_err 1. Next cycle dout lane0 = 5, count 1.
- Flush and reset:
  - At count 5, assert flush with wen wr_num 4 -> next cycle count 0, flags 0, free 8.
  - Later, drop rstn mid-cycle -> outputs clear before the next clk edge.
